reg_wb_queue: RTL and testbench

- Write-back buffer that sits in front of the 32x32 register file's single write port.
- Accepts write-back requests from the execute/memory stage over a valid/ready handshake and buffers them in a small in-order FIFO.
- Drains one entry per enabled cycle onto the register file write port (reg_wr, address, busW).
- Provides two combinational bypass lookups so readers see pending writes before they land.
- Register 31 is not writable in the register file; requests targeting it are accepted and discarded here, and counted.

---
 rtl/reg_pkg.sv | 10 +
 rtl/wb_bypass_lookup.sv | 29 ++
 rtl/reg_wb_queue.sv | 117 +++++++++++
 tb/tb_reg_wb_queue.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/reg_pkg.sv
// reg_pkg: register-file widths, the read-only register index and the write-back entry type.
package reg_pkg;
    localparam int REG_AW = 5;
    localparam int REG_DW = 32;
    localparam logic [REG_AW-1:0] REG_RO_ADDR = 5'd31;
    typedef struct packed {
        logic [REG_AW-1:0] addr;
        logic [REG_DW-1:0] data;
    } wb_entry;
endpackage

// File: rtl/wb_bypass_lookup.sv
// wb_bypass_lookup: youngest-match search over the queued write-backs for one lookup address.
module wb_bypass_lookup
    import reg_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  wb_entry [DEPTH-1:0]         i_ent,
    input  logic [DEPTH-1:0]            i_vld,
    input  logic [$clog2(DEPTH)-1:0]    i_head,
    input  logic [REG_AW-1:0]           i_addr,
    output logic                        o_hit,
    output logic [REG_DW-1:0]           o_data
);
    localparam int PW = $clog2(DEPTH);
    logic [PW-1:0] w_idx;
    // Walk oldest to youngest so the last match left standing is the youngest.
    always_comb begin
        o_hit = 1'b0;
        o_data = '0;
        w_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = i_head + PW'(k);
            if (i_vld[w_idx] && i_ent[w_idx].addr == i_addr && i_addr != REG_RO_ADDR) begin
                o_hit = 1'b1;
                o_data = i_ent[w_idx].data;
            end
        end
    end
endmodule

// File: rtl/reg_wb_queue.sv
// reg_wb_queue: in-order write-back buffer feeding the register file write port, with bypass lookups.
module reg_wb_queue
    import reg_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int DW    = REG_DW,
    parameter int AW    = REG_AW
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_r_type,
    input  logic [AW-1:0]            in_rs2,
    input  logic [AW-1:0]            in_rd,
    input  logic [DW-1:0]            in_data,
    input  logic                     drain_en,
    input  logic                     flush,
    output logic                     reg_wr,
    output logic                     wr_r_type,
    output logic [AW-1:0]            wr_rd,
    output logic [DW-1:0]            wr_data,
    input  logic [AW-1:0]            byp_addr_a,
    input  logic [AW-1:0]            byp_addr_b,
    output logic                     byp_hit_a,
    output logic                     byp_hit_b,
    output logic [DW-1:0]            byp_data_a,
    output logic [DW-1:0]            byp_data_b,
    output logic [$clog2(DEPTH):0]   count,
    output logic [7:0]               drop_cnt
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    wb_entry [DEPTH-1:0] r_ent;
    logic [DEPTH-1:0]    r_vld;
    logic [PW-1:0]       r_head, r_tail;
    logic [CW-1:0]       r_count;
    logic                r_wr;
    logic [AW-1:0]       r_wr_rd;
    logic [DW-1:0]       r_wr_data;
    logic [7:0]          r_drop;
    logic [AW-1:0]       w_dest;
    logic                w_acc, w_enq, w_deq;
    logic                w_qhit_a, w_qhit_b, w_ohit_a, w_ohit_b;
    logic [DW-1:0]       w_qdata_a, w_qdata_b;

    assign w_dest    = in_r_type ? in_rd : in_rs2;
    assign in_ready  = r_count < CW'(DEPTH);
    assign w_acc     = in_valid & in_ready & ~flush;
    assign w_enq     = w_acc & (w_dest != REG_RO_ADDR);
    assign w_deq     = drain_en & (r_count != '0) & ~flush;
    assign reg_wr    = r_wr;
    assign wr_r_type = 1'b1;
    assign wr_rd     = r_wr_rd;
    assign wr_data   = r_wr_data;
    assign count     = r_count;
    assign drop_cnt  = r_drop;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_vld     <= '0;
            r_head    <= '0;
            r_tail    <= '0;
            r_count   <= '0;
            r_wr      <= 1'b0;
            r_wr_rd   <= '0;
            r_wr_data <= '0;
            r_drop    <= '0;
        end else begin
            r_wr <= w_deq;
            if (w_deq) begin
                r_wr_rd   <= r_ent[r_head].addr;
                r_wr_data <= r_ent[r_head].data;
            end
            if (w_acc && !w_enq && r_drop != 8'hFF)
                r_drop <= r_drop + 8'd1;
            if (flush) begin
                r_vld   <= '0;
                r_head  <= '0;
                r_tail  <= '0;
                r_count <= '0;
            end else begin
                if (w_enq) begin
                    r_vld[r_tail] <= 1'b1;
                    r_tail        <= r_tail + 1'b1;
                end
                if (w_deq) begin
                    r_vld[r_head] <= 1'b0;
                    r_head        <= r_head + 1'b1;
                end
                r_count <= r_count + CW'(w_enq) - CW'(w_deq);
            end
        end
    end

    // Entry payload needs no reset; the valid bits alone qualify it.
    always_ff @(posedge clk) begin
        if (w_enq)
            r_ent[r_tail] <= {w_dest, in_data};
    end

    wb_bypass_lookup #(.DEPTH(DEPTH)) u_byp_a (
        .i_ent(r_ent), .i_vld(r_vld), .i_head(r_head), .i_addr(byp_addr_a),
        .o_hit(w_qhit_a), .o_data(w_qdata_a)
    );
    wb_bypass_lookup #(.DEPTH(DEPTH)) u_byp_b (
        .i_ent(r_ent), .i_vld(r_vld), .i_head(r_head), .i_addr(byp_addr_b),
        .o_hit(w_qhit_b), .o_data(w_qdata_b)
    );

    assign w_ohit_a   = r_wr & (r_wr_rd == byp_addr_a) & (byp_addr_a != REG_RO_ADDR);
    assign w_ohit_b   = r_wr & (r_wr_rd == byp_addr_b) & (byp_addr_b != REG_RO_ADDR);
    assign byp_hit_a  = w_qhit_a | w_ohit_a;
    assign byp_hit_b  = w_qhit_b | w_ohit_b;
    assign byp_data_a = w_qhit_a ? w_qdata_a : w_ohit_a ? r_wr_data : '0;
    assign byp_data_b = w_qhit_b ? w_qdata_b : w_ohit_b ? r_wr_data : '0;
endmodule

// File: tb/tb_reg_wb_queue.sv
// tb_reg_wb_queue: directed stimulus with a write scoreboard checked by an independent monitor.
module tb_reg_wb_queue;
    logic        clk = 0, reset = 1, in_valid = 0, in_r_type = 0, drain_en = 0, flush = 0;
    logic [4:0]  in_rs2 = 0, in_rd = 0, byp_addr_a = 0, byp_addr_b = 0;
    logic [31:0] in_data = 0;
    logic        in_ready, reg_wr, wr_r_type, byp_hit_a, byp_hit_b;
    logic [4:0]  wr_rd;
    logic [31:0] wr_data, byp_data_a, byp_data_b;
    logic [2:0]  count;
    logic [7:0]  drop_cnt;
    int checks = 0, errors = 0;
    typedef struct packed {
        logic [4:0]  a;
        logic [31:0] d;
    } exp_t;
    exp_t sb[$];

    reg_wb_queue dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_r_type(in_r_type), .in_rs2(in_rs2), .in_rd(in_rd), .in_data(in_data),
        .drain_en(drain_en), .flush(flush), .reg_wr(reg_wr), .wr_r_type(wr_r_type),
        .wr_rd(wr_rd), .wr_data(wr_data), .byp_addr_a(byp_addr_a), .byp_addr_b(byp_addr_b),
        .byp_hit_a(byp_hit_a), .byp_hit_b(byp_hit_b), .byp_data_a(byp_data_a),
        .byp_data_b(byp_data_b), .count(count), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic rt, input logic [4:0] s2, input logic [4:0] rd,
                        input logic [31:0] d, input bit push);
        in_r_type = rt;
        in_rs2    = s2;
        in_rd     = rd;
        in_data   = d;
        in_valid  = 1;
        if (push) sb.push_back('{a: (rt ? rd : s2), d: d});
        step();
        in_valid = 0;
    endtask

    // Every register-file write must match the oldest expected write.
    always @(negedge clk) begin
        if (reg_wr === 1'b1) begin
            exp_t e;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got rd=%0d data=%0h expected no write", wr_rd, wr_data);
            end else begin
                e = sb.pop_front();
                chk("wr_rd", 32'(wr_rd), 32'(e.a));
                chk("wr_data", wr_data, e.d);
            end
        end
    end

    initial begin
        #2;
        chk("rst_reg_wr", 32'(reg_wr), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_drop", 32'(drop_cnt), 0);
        chk("rst_ready", 32'(in_ready), 1);
        chk("rst_wr_rd", 32'(wr_rd), 0);
        chk("rst_wr_data", wr_data, 0);
        chk("wr_r_type", 32'(wr_r_type), 1);
        step();
        reset = 0;
        drain_en = 1;
        send(1, 0, 5, 32'hDEADBEEF, 1);
        chk("lat_no_fallthrough", 32'(reg_wr), 0);
        chk("lat_count1", 32'(count), 1);
        step();
        chk("lat_reg_wr", 32'(reg_wr), 1);
        chk("lat_wr_rd", 32'(wr_rd), 5);
        chk("lat_wr_data", wr_data, 32'hDEADBEEF);
        chk("lat_count0", 32'(count), 0);
        step();
        chk("lat_pulse_end", 32'(reg_wr), 0);
        drain_en = 0;
        for (int i = 1; i <= 4; i++) send(1, 0, 5'(i), 32'(i * 17), 1);
        chk("full_count", 32'(count), 4);
        chk("full_ready", 32'(in_ready), 0);
        send(1, 0, 9, 32'h99, 0);
        chk("held_count", 32'(count), 4);
        drain_en = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drain_consec", 32'(reg_wr), 1);
        end
        step();
        chk("drain_done_wr", 32'(reg_wr), 0);
        chk("drain_done_count", 32'(count), 0);
        for (int i = 10; i <= 13; i++) send(1, 0, 5'(i), 32'h100 + 32'(i), 1);
        send(0, 12, 31, 32'h1212, 1);
        repeat (2) step();
        chk("wrap_count", 32'(count), 0);
        send(0, 31, 6, 32'h1, 0);
        send(1, 6, 31, 32'h2, 0);
        step();
        chk("drop2", 32'(drop_cnt), 2);
        chk("drop_count", 32'(count), 0);
        repeat (298) send(1, 0, 31, 0, 0);
        chk("drop_sat", 32'(drop_cnt), 255);
        drain_en = 0;
        send(1, 0, 7, 32'hA, 1);
        send(1, 0, 7, 32'hB, 1);
        byp_addr_a = 7;
        byp_addr_b = 8;
        #1;
        chk("byp_hit_a", 32'(byp_hit_a), 1);
        chk("byp_data_young", byp_data_a, 32'hB);
        chk("byp_hit_b_miss", 32'(byp_hit_b), 0);
        chk("byp_data_b_zero", byp_data_b, 0);
        byp_addr_b = 31;
        #1;
        chk("byp_r31_miss", 32'(byp_hit_b), 0);
        flush = 1;
        repeat (2) void'(sb.pop_back());
        step();
        flush = 0;
        chk("flush_count", 32'(count), 0);
        chk("flush_byp_miss", 32'(byp_hit_a), 0);
        drain_en = 1;
        send(1, 0, 20, 32'h55, 1);
        step();
        byp_addr_a = 20;
        #1;
        chk("byp_out_hit", 32'(byp_hit_a), 1);
        chk("byp_out_data", byp_data_a, 32'h55);
        step();
        drain_en = 0;
        for (int i = 1; i <= 4; i++) send(1, 0, 5'(i), 32'h500 + 32'(i), 1);
        chk("ffull_count", 32'(count), 4);
        flush = 1;
        in_r_type = 1;
        in_rd = 15;
        in_data = 32'hF;
        in_valid = 1;
        repeat (4) void'(sb.pop_back());
        step();
        flush = 0;
        in_valid = 0;
        chk("ffull_cleared", 32'(count), 0);
        chk("ffull_ready", 32'(in_ready), 1);
        step();
        chk("ffull_not_stored", 32'(count), 0);
        for (int i = 1; i <= 4; i++) send(1, 0, 5'(i), 32'h600 + 32'(i), 1);
        drain_en = 1;
        step();
        chk("inflight_wr", 32'(reg_wr), 1);
        chk("inflight_count", 32'(count), 3);
        flush = 1;
        repeat (3) void'(sb.pop_back());
        step();
        flush = 0;
        chk("inflight_count0", 32'(count), 0);
        chk("inflight_wr_end", 32'(reg_wr), 0);
        repeat (3) step();
        drain_en = 0;
        for (int i = 1; i <= 3; i++) send(1, 0, 5'(i + 10), 32'h700 + 32'(i), 1);
        drain_en = 1;
        step();
        chk("pre_rst_wr", 32'(reg_wr), 1);
        #1;
        reset = 1;
        #1;
        chk("arst_wr", 32'(reg_wr), 0);
        chk("arst_count", 32'(count), 0);
        chk("arst_wr_rd", 32'(wr_rd), 0);
        chk("arst_drop", 32'(drop_cnt), 0);
        sb.delete();
        step();
        reset = 0;
        repeat (5) step();
        chk("post_rst_count", 32'(count), 0);
        chk("post_rst_wr", 32'(reg_wr), 0);
        chk("sb_empty", 32'(sb.size()), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
